// File: rtl/segasys1_sndlatch.sv
// Main-to-sound CPU command latch: small FIFO of command bytes, one NMI per byte,
// plus the sound CPU's periodic scanline-counted IRQ.
module segasys1_sndlatch #(
  parameter int DEPTH     = 4,
  parameter int NMI_W     = 4,
  parameter int IRQ_LINES = 64
) (
  input  logic       CLK40M,
  input  logic       RESET,
  input  logic       SNDCE,
  input  logic       SNDRQ,
  input  logic [7:0] SNDNO,
  input  logic       SND_RD,
  input  logic       SND_IACK,
  input  logic       LINE_STB,
  input  logic       VBLK,
  output logic [7:0] SND_DO,
  output logic       SND_NMI,
  output logic       SND_IRQ,
  output logic       OVF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [LW-1:0] LINE_LAST = LW'(IRQ_LINES - 1);
  localparam logic [3:0]    NMI_LOAD  = 4'(NMI_W);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, GAP} nmi_state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q, last_d;
  logic          ovf_q, ovf_d;
  logic          rd_q, rd_d, iack_q, iack_d, vblk_q, vblk_d;
  nmi_state_t    state_q, state_d;
  logic [3:0]    nmi_cnt_q, nmi_cnt_d;
  logic          pend_q, pend_d;
  logic [LW-1:0] line_q, line_d;
  logic          irq_q, irq_d;

  logic rd_fall, iack_rise, vblk_rise, empty, full, pop, push, drop, irq_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // FIFO control: the pop is taken at the end of the read cycle so the byte never
  // changes while the sound CPU is still reading it.
  always_comb begin
    rd_d      = SND_RD;
    iack_d    = SND_IACK;
    vblk_d    = VBLK;
    rd_fall   = rd_q & ~SND_RD;
    iack_rise = SND_IACK & ~iack_q;
    vblk_rise = VBLK & ~vblk_q;
    empty     = (count_q == '0);
    full      = (count_q == CNT_FULL);
    pop       = rd_fall & ~empty;
    push      = SNDRQ & (~full | pop);
    drop      = SNDRQ & full & ~pop;
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    last_d = pop ? mem_q[rd_ptr_q] : last_q;
    ovf_d  = ovf_q | drop;
  end

  // A pop seen before WAIT is remembered so the FSM does not need a second read.
  always_comb begin
    state_d   = state_q;
    nmi_cnt_d = nmi_cnt_q;
    pend_d    = pend_q;
    if (pop && state_q != WAIT) pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d   = PULSE;
          nmi_cnt_d = NMI_LOAD;
        end
      end
      PULSE: begin
        if (SNDCE) begin
          nmi_cnt_d = nmi_cnt_q - 4'd1;
          if (nmi_cnt_q == 4'd1) state_d = WAIT;
        end
      end
      WAIT: begin
        if (pop || pend_q) begin
          state_d = GAP;
          pend_d  = 1'b0;
        end
      end
      GAP: begin
        if (SNDCE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d  = line_q;
    irq_set = 1'b0;
    if (vblk_rise) begin
      line_d = '0;
    end else if (LINE_STB) begin
      if (line_q == LINE_LAST) begin
        line_d  = '0;
        irq_set = 1'b1;
      end else begin
        line_d = line_q + LW'(1);
      end
    end
    if (irq_set)        irq_d = 1'b1;
    else if (iack_rise) irq_d = 1'b0;
    else                irq_d = irq_q;
  end

  always_ff @(posedge CLK40M) begin
    if (push) mem_q[wr_ptr_q] <= SNDNO;
  end

  always_ff @(posedge CLK40M or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= '0;
      ovf_q     <= 1'b0;
      rd_q      <= 1'b0;
      iack_q    <= 1'b0;
      vblk_q    <= 1'b0;
      state_q   <= IDLE;
      nmi_cnt_q <= '0;
      pend_q    <= 1'b0;
      line_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_d;
      iack_q    <= iack_d;
      vblk_q    <= vblk_d;
      state_q   <= state_d;
      nmi_cnt_q <= nmi_cnt_d;
      pend_q    <= pend_d;
      line_q    <= line_d;
      irq_q     <= irq_d;
    end
  end

  // When empty the output keeps the last popped byte, like the original latch.
  assign SND_DO  = empty ? last_q : mem_q[rd_ptr_q];
  assign SND_NMI = (state_q == PULSE);
  assign SND_IRQ = irq_q;
  assign OVF     = ovf_q;

endmodule
